// File: rtl/serial_msg_tx_pkg.sv
// Shared types, line levels and helpers for the serial message transmitter.
package serial_msg_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic OUT_IDLE  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/msg_slot_bank.sv
// N_SLOTS x MSG_W message store: async clear, one write port, one combinational read port.
module msg_slot_bank
  import serial_msg_tx_pkg::*;
#(
  parameter int unsigned MSG_W   = 10,
  parameter int unsigned N_SLOTS = 2,
  parameter int unsigned SEL_W   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] sel,
  input  logic [MSG_W-1:0] wr_data,
  output logic [MSG_W-1:0] rd_data_c
);

  logic [MSG_W-1:0] slot_q [N_SLOTS];
  logic [MSG_W-1:0] slot_d [N_SLOTS];

  // Next slot contents: only the addressed slot takes the write data.
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      if (wr_en && (sel == SEL_W'(i))) begin
        slot_d[i] = wr_data;
      end
    end
  end

  // Read mux; an out-of-range select reads zero.
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (sel == SEL_W'(i)) begin
        rd_data_c = slot_q[i];
      end
    end
  end

  // Slot registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule

// File: rtl/serial_msg_tx.sv
// Serial message transmitter: frames a stored slot word as start/data/stop and
// shifts it out at BIT_CYC clocks per bit. Define PARITY_EN to insert an
// even-parity bit between the last data bit and the stop bit.
module serial_msg_tx
  import serial_msg_tx_pkg::*;
#(
  parameter int unsigned MSG_W   = 10,
  parameter int unsigned N_SLOTS = 2,
  parameter int unsigned BIT_CYC = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init,
  input  logic [clog2_min1(N_SLOTS)-1:0]   sel,
  input  logic [MSG_W-1:0]                 SW,
  input  logic                             mode,
  input  logic                             start,
  output logic                             out,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned SEL_W = clog2_min1(N_SLOTS);
  localparam int unsigned BC_W  = clog2_min1(BIT_CYC);
  localparam int unsigned DC_W  = clog2_min1(MSG_W);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(BIT_CYC - 1);
  localparam logic [DC_W-1:0] DATA_LAST = DC_W'(MSG_W - 1);

  state_e           state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DC_W-1:0]  data_cnt_q, data_cnt_d;
  logic [MSG_W-1:0] shreg_q, shreg_d;
  logic             lsb_q, lsb_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             sel_ok_c;
  logic             bit_last_c;
  logic             slot_wr_c;
  logic [MSG_W-1:0] slot_rd_c;
  logic [MSG_W-1:0] shift_c;

  // Bit currently at the head of the shift register for the latched order.
  function automatic logic head_bit(input logic [MSG_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[MSG_W-1];
  endfunction

  assign sel_ok_c   = 32'(sel) < N_SLOTS;
  assign bit_last_c = (bit_cnt_q == BIT_LAST);
  assign slot_wr_c  = init && (state_q == IDLE) && sel_ok_c;
  assign shift_c    = lsb_q ? {1'b0, shreg_q[MSG_W-1:1]} : {shreg_q[MSG_W-2:0], 1'b0};

  msg_slot_bank #(
    .MSG_W  (MSG_W),
    .N_SLOTS(N_SLOTS),
    .SEL_W  (SEL_W)
  ) u_slots (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (slot_wr_c),
    .sel      (sel),
    .wr_data  (SW),
    .rd_data_c(slot_rd_c)
  );

  // Next-state, counter and output computation; out_d is the level for the next cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_cnt_d = data_cnt_q;
    shreg_d    = shreg_q;
    lsb_d      = lsb_q;
    out_d      = out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != IDLE) begin
      bit_cnt_d = bit_last_c ? '0 : bit_cnt_q + BC_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start && sel_ok_c) begin
          state_d    = START;
          shreg_d    = slot_rd_c;
          lsb_d      = mode;
          busy_d     = 1'b1;
          out_d      = START_LVL;
          bit_cnt_d  = '0;
          data_cnt_d = '0;
`ifdef PARITY_EN
          parity_d   = ^slot_rd_c;
`endif
        end
      end
      START: begin
        if (bit_last_c) begin
          state_d = DATA;
          out_d   = head_bit(shreg_q, lsb_q);
        end
      end
      DATA: begin
        if (bit_last_c) begin
          shreg_d = shift_c;
          if (data_cnt_q == DATA_LAST) begin
            data_cnt_d = '0;
`ifdef PARITY_EN
            state_d    = PARITY;
            out_d      = parity_q;
`else
            state_d    = STOP;
            out_d      = STOP_LVL;
`endif
          end else begin
            data_cnt_d = data_cnt_q + DC_W'(1);
            out_d      = head_bit(shift_c, lsb_q);
          end
        end
      end
      PARITY: begin
        if (bit_last_c) begin
          state_d = STOP;
          out_d   = STOP_LVL;
        end
      end
      STOP: begin
        if (bit_last_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          out_d   = OUT_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        out_d   = OUT_IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      data_cnt_q <= '0;
      shreg_q    <= '0;
      lsb_q      <= 1'b0;
      out_q      <= OUT_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_cnt_q <= data_cnt_d;
      shreg_q    <= shreg_d;
      lsb_q      <= lsb_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_msg_tx.sv
// Bench for serial_msg_tx: two instances (1 and 4 clocks per bit) share the
// stimulus and are checked every cycle against a frame-level reference model.
module tb_serial_msg_tx;
  import serial_msg_tx_pkg::*;

  localparam int unsigned MSG_W   = 10;
  localparam int unsigned N_SLOTS = 2;
  localparam int unsigned SEL_W   = clog2_min1(N_SLOTS);
`ifdef PARITY_EN
  localparam int unsigned FB = MSG_W + 3;
  localparam logic [15:0] EXP_MSB = 16'(13'b0_1000110101_1_1);
  localparam logic [15:0] EXP_LSB = 16'(13'b0_1010110001_1_1);
  localparam logic [15:0] EXP_S1  = 16'(13'b0_1001101101_0_1);
`else
  localparam int unsigned FB = MSG_W + 2;
  localparam logic [15:0] EXP_MSB = 16'(12'b0_1000110101_1);
  localparam logic [15:0] EXP_LSB = 16'(12'b0_1010110001_1);
  localparam logic [15:0] EXP_S1  = 16'(12'b0_1001101101_1);
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             init = 1'b0;
  logic [SEL_W-1:0] sel = '0;
  logic [MSG_W-1:0] SW = '0;
  logic             mode = 1'b0;
  logic             start = 1'b0;
  logic             out1, busy1, done1;
  logic             out4, busy4, done4;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: remaining frame cycles, frame bits (bit 0 sent first), slots.
  int unsigned      rem   [2];
  logic [15:0]      fbits [2];
  logic             mdone [2];
  logic [MSG_W-1:0] mslot [2][N_SLOTS];

  always #5 clk = ~clk;

  serial_msg_tx #(.MSG_W(MSG_W), .N_SLOTS(N_SLOTS), .BIT_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .init(init), .sel(sel), .SW(SW), .mode(mode),
    .start(start), .out(out1), .busy(busy1), .done(done1)
  );

  serial_msg_tx #(.MSG_W(MSG_W), .N_SLOTS(N_SLOTS), .BIT_CYC(4)) u_dut4 (
    .clk(clk), .rst(rst), .init(init), .sel(sel), .SW(SW), .mode(mode),
    .start(start), .out(out4), .busy(busy4), .done(done4)
  );

  function automatic int unsigned bc_of(input int k);
    return (k == 0) ? 32'd1 : 32'd4;
  endfunction

  function automatic logic exp_out(input int k);
    int unsigned bc;
    bc = bc_of(k);
    if (rem[k] == 0) return 1'b1;
    return fbits[k][(FB * bc - rem[k]) / bc];
  endfunction

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic checkv(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the model for instance k, using the inputs present before the edge.
  task automatic model_step(input int k);
    bit               idle;
    logic [MSG_W-1:0] w;
    bit               ok;
    idle     = (rem[k] == 0);
    ok       = 32'(sel) < N_SLOTS;
    mdone[k] = (rem[k] == 1);
    if (!idle) rem[k]--;
    if (idle && start && ok) begin
      w = mslot[k][sel];
      fbits[k] = '0;
      fbits[k][0] = 1'b0;
      for (int j = 0; j < MSG_W; j++) fbits[k][1 + j] = mode ? w[j] : w[MSG_W - 1 - j];
`ifdef PARITY_EN
      fbits[k][MSG_W + 1] = ^w;
`endif
      fbits[k][FB - 1] = 1'b1;
      rem[k] = FB * bc_of(k);
    end
    if (idle && init && ok) mslot[k][sel] = SW;
  endtask

  // Model update process.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      for (int k = 0; k < 2; k++) begin
        if (!rst) begin
          rem[k] = 0;
          mdone[k] = 1'b0;
          fbits[k] = '0;
          for (int s = 0; s < N_SLOTS; s++) mslot[k][s] = '0;
        end else begin
          model_step(k);
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check1("out_bc1", out1, exp_out(0));
        check1("busy_bc1", busy1, rem[0] != 0);
        check1("done_bc1", done1, mdone[0]);
        check1("out_bc4", out4, exp_out(1));
        check1("busy_bc4", busy4, rem[1] != 0);
        check1("done_bc4", done4, mdone[1]);
      end
    end
  end

  // Send slot s with order m on the 1-clock instance and check the whole frame against a literal.
  task automatic run_lit(input string nm, input logic [SEL_W-1:0] s, input logic m,
                         input logic [15:0] exp, input bit poke);
    logic [63:0] o, b, d, eo, eb, ed;
    o = '0; b = '0; d = '0; eo = '0; eb = '0; ed = '0;
    sel = s; mode = m; start = 1'b1;
    for (int i = 0; i <= FB; i++) begin
      @(negedge clk);
      start = 1'b0;
      init  = 1'b0;
      if (poke && i == 3) begin
        init = 1'b1; sel = '0; SW = '1;
      end
      if (poke && i == 5) begin
        start = 1'b1; sel = SEL_W'(1);
      end
      o[i] = out1; b[i] = busy1; d[i] = done1;
      if (i < FB) begin
        eo[i] = exp[FB - 1 - i]; eb[i] = 1'b1;
      end else begin
        eo[i] = 1'b1; ed[i] = 1'b1;
      end
    end
    checkv({nm, "_out"}, o, eo);
    checkv({nm, "_busy"}, b, eb);
    checkv({nm, "_done"}, d, ed);
  endtask

  initial begin
    logic [63:0] o, b, d, eo, eb, ed;
    int          guard;

    // Reset held low.
    repeat (3) @(negedge clk);
    check1("rst_out1", out1, 1'b1);
    check1("rst_busy1", busy1, 1'b0);
    check1("rst_done1", done1, 1'b0);
    check1("rst_out4", out4, 1'b1);
    check1("rst_busy4", busy4, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Literal frames on the 1-clock instance.
    init = 1'b1; sel = '0; SW = 10'b1000110101;
    @(negedge clk);
    init = 1'b0;
    run_lit("msb_s0", '0, 1'b0, EXP_MSB, 1'b0);
    run_lit("lsb_s0", '0, 1'b1, EXP_LSB, 1'b0);
    init = 1'b1; sel = SEL_W'(1); SW = 10'b1001101101;
    @(negedge clk);
    init = 1'b0;
    run_lit("msb_s1", SEL_W'(1), 1'b0, EXP_S1, 1'b0);
    run_lit("poked", '0, 1'b0, EXP_MSB, 1'b1);
    run_lit("after_poke", '0, 1'b0, EXP_MSB, 1'b0);

    // Asynchronous reset in the middle of a frame.
    sel = '0; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check1("pre_rst_busy1", busy1, 1'b1);
    #2 rst = 1'b0;
    #1;
    check1("async_out1", out1, 1'b1);
    check1("async_busy1", busy1, 1'b0);
    check1("async_out4", out4, 1'b1);
    check1("async_busy4", busy4, 1'b0);
    @(negedge clk);
    check1("async_no_done1", done1, 1'b0);
    rst = 1'b1;

    // Held start on the 4-clock instance: 4 cycles per bit, next frame right after done.
    init = 1'b1; sel = '0; SW = 10'b1000110101;
    @(negedge clk);
    init = 1'b0; mode = 1'b0; start = 1'b1;
    o = '0; b = '0; d = '0; eo = '0; eb = '0; ed = '0;
    for (int i = 0; i < FB * 4 + 2; i++) begin
      @(negedge clk);
      o[i] = out4; b[i] = busy4; d[i] = done4;
      if (i < FB * 4) begin
        eo[i] = EXP_MSB[FB - 1 - i / 4]; eb[i] = 1'b1;
      end else if (i == FB * 4) begin
        eo[i] = 1'b1; ed[i] = 1'b1;
      end else begin
        eo[i] = 1'b0; eb[i] = 1'b1;
      end
    end
    start = 1'b0;
    checkv("held_out4", o, eo);
    checkv("held_busy4", b, eb);
    checkv("held_done4", d, ed);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      init  = ($urandom % 8) == 0;
      start = ($urandom % 5) == 0;
      sel   = SEL_W'($urandom);
      mode  = 1'($urandom);
      SW    = MSG_W'($urandom);
      if (($urandom % 600) == 0) begin
        #2 rst = 1'b0;
        #1;
        check1("rand_rst_out1", out1, 1'b1);
        check1("rand_rst_busy4", busy4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
      end
    end
    init = 1'b0; start = 1'b0;

    // Drain both instances within a bounded number of cycles.
    guard = 0;
    while ((busy1 || busy4) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check1("drain_idle", busy1 | busy4, 1'b0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
